// File: rtl/ppcpu_pkg.sv
// Shared types and constants for the pipelined CPU memory-side blocks.
// Holds the responder state encoding, the word width and the address decode helper.
package ppcpu_pkg;

  localparam int WORD_W = 32;

  // Byte-offset bits that must be zero for a word access.
  localparam logic [WORD_W-1:0] ALIGN_MASK = 32'h0000_0003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // A word address is legal when aligned and inside the 2^depth_log2-word window.
  function automatic logic addr_err(input logic [WORD_W-1:0] a, input int depth_log2);
    return ((a & ALIGN_MASK) != '0) || ((a >> (depth_log2 + 2)) != '0);
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// 2^DEPTH_LOG2 x 32 word store: synchronous write, registered read, no reset.
// The read register samples the pre-write contents when waddr == raddr.
module mem_word_array
  import ppcpu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  Clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge Clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/stall_mem_responder.sv
// Memory responder with programmable wait states that freezes the pipeline while busy.
// Handshake: req is held with addr/we/wdata stable until ready; ready is a one-cycle strobe.
module stall_mem_responder
  import ppcpu_pkg::*;
#(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              stall,
  output state_e            state_dbg
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [WORD_W-1:0]     addr_q, wdata_q;
  logic                  we_q;

  logic                  capture, enter_resp;
  logic [WORD_W-1:0]     cur_addr, cur_wdata;
  logic                  cur_we, cur_err;
  logic [DEPTH_LOG2-1:0] cur_idx, rsp_idx_q, arr_raddr;
  logic                  arr_we;
  logic [WORD_W-1:0]     arr_rdata;
  logic                  rd_sel_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == CNT_ONE) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall     = ((state_q == IDLE) && req) || (state_q == WAIT);
    state_dbg = state_q;
  end

  // With zero wait states the capture and response edges coincide, so the
  // live request fields feed the decode while IDLE.
  assign capture    = (state_q == IDLE) && req;
  assign enter_resp = (state_d == RESP);
  assign cur_addr   = (state_q == IDLE) ? addr  : addr_q;
  assign cur_wdata  = (state_q == IDLE) ? wdata : wdata_q;
  assign cur_we     = (state_q == IDLE) ? we    : we_q;
  assign cur_err    = addr_err(cur_addr, DEPTH_LOG2);
  assign cur_idx    = cur_addr[DEPTH_LOG2+1:2];

  assign arr_we = enter_resp && cur_we && !cur_err;

  // Between responses the array keeps re-reading the last response index; that
  // word only changes on a write's response edge, which also zeroes rdata.
  assign arr_raddr = enter_resp ? cur_idx : rsp_idx_q;

  mem_word_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .Clock (Clock),
    .we    (arr_we),
    .waddr (cur_idx),
    .wdata (cur_wdata),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rsp_idx_q <= '0;
      rd_sel_q  <= 1'b0;
      ready     <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (capture) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        we_q    <= we;
        cnt_q   <= CNT_LOAD;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - CNT_ONE;
      end
      ready <= enter_resp;
      err   <= enter_resp && cur_err;
      if (enter_resp) begin
        rsp_idx_q <= cur_idx;
        rd_sel_q  <= !cur_we && !cur_err;
      end
    end
  end

  assign rdata = rd_sel_q ? arr_rdata : '0;

endmodule
